// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: enumerates every BITS-wide word with exactly K set bits, ascending, on a valid/ready stream
// Ports: clk/rst (sync, active-high); start + count_in request a sequence of K-ones words;
// out_valid/out_ready/pattern/last carry the stream; busy is high while emitting;
// done pulses after the final handshake; err pulses when start is accepted with K > BITS.
module ones_pattern_gen #(
  parameter int BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(BITS+1)-1:0] count_in,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BITS-1:0]           pattern,
  output logic                      last,
  output logic                      done,
  output logic                      err
);
  localparam int CW = $clog2(BITS+1);
  localparam logic [CW-1:0] BW = CW'(BITS);
  localparam logic [BITS:0] ONE = {{BITS{1'b0}}, 1'b1};
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] k_q, k_d, tz;
  logic [BITS-1:0] pattern_q, pattern_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, err_q, err_d;
  logic [BITS:0] x, c, r, t, nxt, hi;
  // Gosper's hack in BITS+1 bits; the carry out of r lands in bit BITS and is dropped on truncation
  always_comb begin
    x = {1'b0, pattern_q};
    c = x & (~x + ONE);
    r = x + c;
    t = x ^ r;
    tz = '0;
    for (int i = 0; i <= BITS; i++) if (c[i]) tz = CW'(i);
    nxt = r | ((t >> tz) >> 2);
    hi = ((ONE << k_q) - ONE) << (BW - k_q);
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    pattern_d = pattern_q;
    valid_d = valid_q;
    last_d = last_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && count_in > BW) err_d = 1'b1;
      else if (start) begin
        k_d = count_in;
        pattern_d = BITS'((ONE << count_in) - ONE);
        valid_d = 1'b1;
        last_d = count_in == '0 || count_in == BW;
        state_d = EMIT;
      end
    end else if (valid_q && out_ready) begin
      if (last_q) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end else begin
        pattern_d = BITS'(nxt);
        last_d = nxt == hi;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      pattern_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      pattern_q <= pattern_d;
      valid_q <= valid_d;
      last_q <= last_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q == EMIT;
  assign out_valid = valid_q;
  assign pattern = pattern_q;
  assign last = last_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: directed checks of ones_pattern_gen at BITS=4, 8 and 16
module tb_ones_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic a_start = 0, a_ready = 0, a_busy, a_valid, a_last, a_done, a_err;
  logic [2:0] a_cnt = '0;
  logic [3:0] a_pat;
  logic b_start = 0, b_ready = 0, b_busy, b_valid, b_last, b_done, b_err;
  logic [4:0] b_cnt = '0;
  logic [15:0] b_pat;
  logic c_start = 0, c_ready = 0, c_busy, c_valid, c_last, c_done, c_err;
  logic [3:0] c_cnt = '0;
  logic [7:0] c_pat;
  ones_pattern_gen #(.BITS(4)) u4 (.clk(clk), .rst(rst), .start(a_start), .count_in(a_cnt), .busy(a_busy),
    .out_valid(a_valid), .out_ready(a_ready), .pattern(a_pat), .last(a_last), .done(a_done), .err(a_err));
  ones_pattern_gen #(.BITS(16)) u16 (.clk(clk), .rst(rst), .start(b_start), .count_in(b_cnt), .busy(b_busy),
    .out_valid(b_valid), .out_ready(b_ready), .pattern(b_pat), .last(b_last), .done(b_done), .err(b_err));
  ones_pattern_gen #(.BITS(8)) u8 (.clk(clk), .rst(rst), .start(c_start), .count_in(c_cnt), .busy(c_busy),
    .out_valid(c_valid), .out_ready(c_ready), .pattern(c_pat), .last(c_last), .done(c_done), .err(c_err));
  logic [3:0] exp4 [6] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
  int bin8 [9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] next_same(input logic [15:0] v);
    logic [16:0] y;
    y = {1'b0, v} + 17'd1;
    while ($countones(y[15:0]) != $countones(v)) y = y + 17'd1;
    return y[15:0];
  endfunction
  initial begin
    int idx, n;
    logic [15:0] e;
    logic [7:0] prev;
    step;
    step;
    rst = 1'b0;
    chk("rst_valid", b_valid, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_pat", b_pat, 0);
    chk("rst_last", b_last, 0);
    chk("rst_done", b_done, 0);
    chk("rst_err", b_err, 0);
    chk("rst_valid4", a_valid, 0);
    // BITS=4, K=2, always ready
    a_cnt = 3'd2;
    a_start = 1'b1;
    a_ready = 1'b1;
    step;
    a_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("k2_valid", a_valid, 1);
      chk("k2_busy", a_busy, 1);
      chk("k2_pat", a_pat, exp4[i]);
      chk("k2_last", a_last, i == 5);
      chk("k2_done_early", a_done, 0);
      step;
    end
    chk("k2_done", a_done, 1);
    chk("k2_busy_fall", a_busy, 0);
    chk("k2_valid_fall", a_valid, 0);
    step;
    chk("k2_done_pulse", a_done, 0);
    // BITS=4, K=2, ready pattern 1,0,0 repeating
    a_start = 1'b1;
    step;
    a_start = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && !a_done; cyc++) begin
      a_ready = (cyc % 3) == 0;
      if (a_valid && idx < 6) begin
        chk("bp_pat", a_pat, exp4[idx]);
        chk("bp_last", a_last, idx == 5);
      end
      if (a_valid && a_ready) idx++;
      step;
    end
    chk("bp_count", idx, 6);
    chk("bp_done", a_done, 1);
    a_ready = 1'b1;
    step;
    // BITS=16, K=0 then K=16
    b_ready = 1'b1;
    b_cnt = 5'd0;
    b_start = 1'b1;
    step;
    b_start = 1'b0;
    chk("k0_valid", b_valid, 1);
    chk("k0_pat", b_pat, 16'h0000);
    chk("k0_last", b_last, 1);
    step;
    chk("k0_done", b_done, 1);
    chk("k0_valid_fall", b_valid, 0);
    step;
    b_cnt = 5'd16;
    b_start = 1'b1;
    step;
    b_start = 1'b0;
    chk("k16_valid", b_valid, 1);
    chk("k16_pat", b_pat, 16'hFFFF);
    chk("k16_last", b_last, 1);
    step;
    chk("k16_done", b_done, 1);
    chk("k16_busy", b_busy, 0);
    step;
    // K > BITS
    b_cnt = 5'd17;
    b_start = 1'b1;
    step;
    b_start = 1'b0;
    chk("err_pulse", b_err, 1);
    chk("err_valid", b_valid, 0);
    chk("err_busy", b_busy, 0);
    step;
    chk("err_clear", b_err, 0);
    chk("err_valid2", b_valid, 0);
    chk("err_busy2", b_busy, 0);
    // K=1 walks a single one
    b_cnt = 5'd1;
    b_start = 1'b1;
    step;
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("k1_valid", b_valid, 1);
      chk("k1_pat", b_pat, 32'(1) << i);
      chk("k1_last", b_last, i == 15);
      step;
    end
    chk("k1_done", b_done, 1);
    step;
    // K=8, reset after 10 handshakes
    b_cnt = 5'd8;
    b_start = 1'b1;
    step;
    b_start = 1'b0;
    e = 16'h00FF;
    for (int i = 0; i < 10; i++) begin
      chk("k8_pat", b_pat, e);
      e = next_same(e);
      step;
    end
    chk("k8_pat11", b_pat, e);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_valid", b_valid, 0);
    chk("mid_rst_busy", b_busy, 0);
    chk("mid_rst_pat", b_pat, 0);
    chk("mid_rst_last", b_last, 0);
    chk("mid_rst_done", b_done, 0);
    chk("mid_rst_err", b_err, 0);
    step;
    chk("mid_rst_nodone", b_done, 0);
    b_start = 1'b1;
    step;
    b_start = 1'b0;
    chk("restart_valid", b_valid, 1);
    chk("restart_pat", b_pat, 16'h00FF);
    // BITS=8, every K: popcount, ascending order, C(8,K) handshakes
    c_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      c_cnt = 4'(k);
      c_start = 1'b1;
      step;
      c_start = 1'b0;
      n = 0;
      prev = '0;
      for (int cyc = 0; cyc < 100 && !c_done; cyc++) begin
        if (c_valid) begin
          chk("b8_popcount", $countones(c_pat), k);
          if (n > 0) chk("b8_ascending", c_pat > prev, 1);
          prev = c_pat;
          n++;
        end
        step;
      end
      chk("b8_done", c_done, 1);
      chk("b8_count", n, bin8[k]);
      step;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
